// File: rtl/rx_deser.sv
// Oversampling UART receiver: 8N1 frames, mid-bit sampling driven by os_tick,
// single-entry output holding register with overrun and framing-error pulses.
module rx_deser #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       os_tick,
    input  logic       rx,
    input  logic       rx_read,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic          rx_meta_p0;
    logic          rx_sync_p1;
    logic [2:0]    state;
    logic [CW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          stop_sample;
    logic          accept;
    logic          bad_stop;

    // Synchronizer stage: both flops idle high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_meta_p0 <= rx;
            rx_sync_p1 <= rx_meta_p0;
        end
    end

    assign stop_sample = (state == S_STOP) && os_tick && (tick_cnt == FULL_M1);
    assign accept      = stop_sample && rx_sync_p1;
    assign bad_stop    = stop_sample && !rx_sync_p1;
    assign rx_busy     = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rx_sync_p1) begin
                        state    <= S_START;
                        tick_cnt <= '0;
                    end
                end
                S_START: begin
                    if (os_tick) begin
                        if (tick_cnt == HALF_M1) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= rx_sync_p1 ? S_IDLE : S_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + CW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (os_tick) begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_sync_p1, shreg[7:1]};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= S_STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CW'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (os_tick) begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt <= '0;
                            state    <= rx_sync_p1 ? S_IDLE : S_WAIT_HIGH;
                        end else begin
                            tick_cnt <= tick_cnt + CW'(1);
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    // A held-low (break) line must not be mistaken for a new start bit.
                    if (rx_sync_p1) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output stage: a read coincident with an accept hands over the new byte without overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            overrun   <= 1'b0;
            if (accept) begin
                if (!rx_valid || rx_read) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_read) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_deser.sv
// Bench for rx_deser: a behavioural serial transmitter drives frames tick by tick,
// and a consumer-level model predicts rx_data, rx_valid and pulse counts.
module tb_rx_deser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       os_tick = 1'b0;
    logic       rx = 1'b1;
    logic       rx_read;
    logic       man_read = 1'b0;
    logic       auto_read = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int   errors = 0;
    int   checks = 0;
    int   ticks = 0;
    int   div = 0;
    int   read_tick = -1;
    int   ferr_cnt = 0;
    int   ovr_cnt = 0;
    int   rise_tick = -1;
    bit   rise_on_tick = 1'b0;
    bit   valid_q = 1'b0;
    bit   tick_was;
    int   last_start = 0;
    event tick_ev;

    // Consumer-level expectations
    bit         m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    int         m_ferr = 0;
    int         m_ovr = 0;

    assign rx_read = man_read | auto_read;

    rx_deser #(.OVERSAMPLE(16)) dut (
        .clk(clk), .rst(rst), .os_tick(os_tick), .rx(rx), .rx_read(rx_read),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Tick generator, pulse counters and rx_valid rise monitor, all on the falling edge.
    always @(negedge clk) begin
        tick_was = os_tick;
        if (tick_was) ticks++;
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (rx_valid && !valid_q) begin
            rise_tick = ticks;
            rise_on_tick = tick_was;
        end
        valid_q = rx_valid;
        div = (div + 1) % 4;
        os_tick = (div == 3);
        auto_read = os_tick && (ticks + 1 == read_tick);
        if (tick_was) -> tick_ev;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Stop-bit sample lands 8 + 9*16 = 152 ticks after the start edge is driven.
    task automatic model_frame(input logic [7:0] b, input bit stop, input int off);
        if (stop) begin
            if (!m_valid || off == 152) begin
                m_data = b;
                m_valid = 1'b1;
            end else begin
                m_ovr++;
            end
        end else begin
            m_ferr++;
            if (off == 152) m_valid = 1'b0;
        end
        if (off > 152) m_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input int off, input int gap);
        last_start = ticks;
        if (off > 0) read_tick = last_start + off;
        rx = 1'b0;
        repeat (16) @(tick_ev);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(tick_ev);
        end
        rx = stop;
        repeat (16) @(tick_ev);
        read_tick = -1;
        model_frame(b, stop, off);
        if (gap > 0) begin
            rx = 1'b1;
            repeat (gap) @(tick_ev);
        end
    endtask

    task automatic do_read();
        @(negedge clk) man_read = 1'b1;
        @(negedge clk) man_read = 1'b0;
        if (m_valid) m_valid = 1'b0;
        @(tick_ev);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
        checks++; if ({frame_err, overrun} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {frame_err, overrun}); end
        @(negedge clk) rst = 1'b0;
        repeat (4) @(tick_ev);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy got=%b exp=0", rx_busy); end
    endtask

    task automatic test_a5();
        rise_tick = -1;
        send_frame(8'hA5, 1'b1, 0, 4);
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL a5_data got=%h exp=a5", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL a5_valid got=%b exp=1", rx_valid); end
        checks++; if (rise_tick !== last_start + 152 || !rise_on_tick) begin
            errors++; $display("FAIL a5_latency got_tick=%0d on_tick=%0d exp_tick=%0d", rise_tick - last_start, rise_on_tick, 152);
        end
        checks++; if (ferr_cnt !== 0 || ovr_cnt !== 0) begin errors++; $display("FAIL a5_pulses ferr=%0d ovr=%0d exp=0/0", ferr_cnt, ovr_cnt); end
    endtask

    task automatic test_false_start();
        logic [7:0] d0;
        d0 = rx_data;
        rx = 1'b0;
        repeat (3) @(tick_ev);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL false_start_busy got=%b exp=1", rx_busy); end
        rx = 1'b1;
        repeat (12) @(tick_ev);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL false_start_idle got=%b exp=0", rx_busy); end
        checks++; if (rx_data !== d0 || rx_valid !== m_valid) begin
            errors++; $display("FAIL false_start_out data=%h valid=%b exp=%h/%b", rx_data, rx_valid, d0, m_valid);
        end
        checks++; if (ferr_cnt !== m_ferr || ovr_cnt !== m_ovr) begin errors++; $display("FAIL false_start_pulses ferr=%0d ovr=%0d exp=%0d/%0d", ferr_cnt, ovr_cnt, m_ferr, m_ovr); end
    endtask

    task automatic test_frame_err();
        do_read();
        send_frame(8'h3C, 1'b0, 0, 0);
        repeat (40) @(tick_ev);
        checks++; if (ferr_cnt !== m_ferr) begin errors++; $display("FAIL ferr_count got=%0d exp=%0d", ferr_cnt, m_ferr); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL ferr_wait_high busy got=%b exp=1", rx_busy); end
        rx = 1'b1;
        repeat (4) @(tick_ev);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_release busy got=%b exp=0", rx_busy); end
        send_frame(8'h81, 1'b1, 0, 4);
        checks++; if (rx_data !== 8'h81 || rx_valid !== 1'b1) begin errors++; $display("FAIL ferr_next data=%h valid=%b exp=81/1", rx_data, rx_valid); end
    endtask

    task automatic test_overrun();
        do_read();
        send_frame(8'h11, 1'b1, 0, 4);
        send_frame(8'h22, 1'b1, 0, 4);
        checks++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin errors++; $display("FAIL overrun_keep data=%h valid=%b exp=11/1", rx_data, rx_valid); end
        checks++; if (ovr_cnt !== m_ovr || m_ovr !== 1) begin errors++; $display("FAIL overrun_pulse got=%0d exp=%0d", ovr_cnt, m_ovr); end
        do_read();
        send_frame(8'h11, 1'b1, 0, 4);
        send_frame(8'h22, 1'b1, 152, 4);
        checks++; if (rx_data !== 8'h22 || rx_valid !== 1'b1) begin errors++; $display("FAIL coincident_read data=%h valid=%b exp=22/1", rx_data, rx_valid); end
        checks++; if (ovr_cnt !== m_ovr) begin errors++; $display("FAIL coincident_no_overrun got=%0d exp=%0d", ovr_cnt, m_ovr); end
    endtask

    task automatic test_reset_mid_frame();
        int f0;
        int o0;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        rx = 1'b0;
        repeat (16) @(tick_ev);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            repeat (16) @(tick_ev);
        end
        rx = 1'b1;
        repeat (8) @(tick_ev);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_busy !== 1'b0) begin
            errors++; $display("FAIL midreset_out data=%h valid=%b busy=%b exp=00/0/0", rx_data, rx_valid, rx_busy);
        end
        m_valid = 1'b0;
        m_data = 8'h00;
        repeat (3) @(tick_ev);
        rst = 1'b0;
        repeat (20) @(tick_ev);
        checks++; if (ferr_cnt !== f0 || ovr_cnt !== o0 || rx_valid !== 1'b0 || rx_busy !== 1'b0) begin
            errors++; $display("FAIL midreset_quiet ferr=%0d ovr=%0d valid=%b busy=%b exp=%0d/%0d/0/0", ferr_cnt, ovr_cnt, rx_valid, rx_busy, f0, o0);
        end
        send_frame(8'h7E, 1'b1, 0, 4);
        checks++; if (rx_data !== 8'h7E || rx_valid !== 1'b1) begin errors++; $display("FAIL midreset_next data=%h valid=%b exp=7e/1", rx_data, rx_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3];
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h55;
        do_read();
        for (int i = 0; i < 3; i++) begin
            send_frame(seq[i], 1'b1, 156, 0);
            checks++; if (rx_data !== seq[i] || rx_valid !== 1'b0) begin
                errors++; $display("FAIL b2b_byte%0d data=%h valid=%b exp=%h/0", i, rx_data, rx_valid, seq[i]);
            end
        end
        rx = 1'b1;
        repeat (4) @(tick_ev);
        checks++; if (ferr_cnt !== m_ferr || ovr_cnt !== m_ovr) begin errors++; $display("FAIL b2b_pulses ferr=%0d ovr=%0d exp=%0d/%0d", ferr_cnt, ovr_cnt, m_ferr, m_ovr); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit         stop;
        int         mode;
        int         off;
        for (int n = 0; n < 8; n++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            mode = $urandom_range(0, 3);
            off = (mode == 1) ? 152 : (mode == 2) ? 156 : 0;
            if (mode == 3) do_read();
            send_frame(b, stop, off, 4);
            checks++; if (rx_data !== m_data || rx_valid !== m_valid) begin
                errors++; $display("FAIL rand%0d data=%h valid=%b exp=%h/%b", n, rx_data, rx_valid, m_data, m_valid);
            end
            checks++; if (ferr_cnt !== m_ferr || ovr_cnt !== m_ovr) begin
                errors++; $display("FAIL rand%0d_pulses ferr=%0d ovr=%0d exp=%0d/%0d", n, ferr_cnt, ovr_cnt, m_ferr, m_ovr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_a5();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_deser.md
RX_DESER -- requirements
Module: rx_deser

Interface
REQ-001 SHALL have parameter: OVERSAMPLE, 16, os_tick pulses per bit period (even, >=4).
REQ-002 SHALL have port: clk  input  1  clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: os_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate.
REQ-005 SHALL have port: rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port: rx_read  input  1  consumer acknowledge; clears rx_valid.
REQ-007 SHALL have port: rx_data  output  8  last accepted byte.
REQ-008 SHALL have port: rx_valid  output  1  rx_data holds an unread byte.
REQ-009 SHALL have port: rx_busy  output  1  high whenever FSM is not IDLE.
REQ-010 SHALL have port: frame_err  output  1  one-clk pulse, stop bit sampled low.
REQ-011 SHALL have port: overrun  output  1  one-clk pulse, byte dropped because rx_valid was still set.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer, both flops reset to 1; all decisions use the synchronized value.
REQ-013 SHALL accept frame format: 1 start (0), 8 data LSB first, 1 stop (1), no parity.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH; the tick counter and bit counter advance only on os_tick.
REQ-015 IDLE: synchronized rx == 0 on any clk -> START, tick counter cleared.
REQ-016 START: after OVERSAMPLE/2 os_ticks, resample; 0 -> DATA, counter cleared; 1 -> false start, back to IDLE with no output activity.
REQ-017 DATA: sample once every OVERSAMPLE os_ticks (mid-bit) and shift into bit 7 of a shift register (LSB-first); after the 8th sample -> STOP.
REQ-018 STOP: sample after OVERSAMPLE os_ticks; 1 -> accept byte, IDLE; 0 -> frame_err pulse, byte discarded, WAIT_HIGH.
REQ-019 WAIT_HIGH: stay until synchronized rx == 1, then IDLE (break/stuck-low line never re-triggers).
REQ-020 Accept with rx_valid == 0: rx_data loaded, rx_valid set on the clk following the stop-sample os_tick.
REQ-021 Accept with rx_valid == 1 and rx_read == 0: byte dropped, rx_data unchanged, rx_valid stays 1, overrun pulses one clk.
REQ-022 Accept coincident with rx_read == 1: new byte loaded, rx_valid stays 1, no overrun.
REQ-023 rx_read with rx_valid == 1 and no accept: rx_valid clears next clk; rx_read with rx_valid == 0: no effect.
REQ-024 rx_data SHALL not change except on a non-dropped accept.
REQ-025 os_tick inactive SHALL freeze all counters; rx_read handling remains active every clk.
REQ-026 Ready for the next start bit immediately on return to IDLE (mid-stop-bit), supporting back-to-back frames from the companion transmitter.

Reset
REQ-027 On rst: state IDLE, counters 0, shift register 0, synchronizer 1, rx_data 8'h00, rx_valid 0, rx_busy 0, frame_err 0, overrun 0.
REQ-028 rst asserted mid-frame SHALL abandon the frame with no valid, frame_err or overrun pulse; after release, a low line is treated as a new start.

Verification
REQ-029 Frame 0xA5 at OVERSAMPLE=16, os_tick every 4 clk -> rx_data=0xA5, rx_valid=1 one clk after stop-sample tick, frame_err=0, overrun=0.
REQ-030 rx low for 3 os_ticks then high -> FSM returns to IDLE, rx_valid=0, rx_data unchanged.
REQ-031 Frame 0x3C with stop bit 0, line then held low 40 ticks -> one frame_err pulse, rx_valid=0, stays WAIT_HIGH; next valid 0x81 -> rx_data=0x81.
REQ-032 Frames 0x11 then 0x22 without rx_read -> rx_data=0x11, rx_valid=1, one overrun pulse; rx_read at stop-sample of 0x22 instead -> rx_data=0x22, no overrun.
REQ-033 rst pulse during data bit 4 -> all outputs at reset values, no pulses; following frame 0x7E received correctly.
REQ-034 Loopback from companion transmitter, baud_tick every 16 os_ticks, back-to-back 0x00, 0xFF, 0x55 with rx_read each -> three bytes in order, no errors.
